// File: rtl/avst_pkt_gen_pkg.sv
// rtl/avst_pkt_gen_pkg.sv - FSM state type and field widths for the packet generator
package avst_pkt_gen_pkg;

  localparam int LEN_W  = 16;
  localparam int CNT_W  = 16;
  localparam int GAP_W  = 8;
  localparam int STAT_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/generic_func_pack.sv
// rtl/generic_func_pack.sv - shared elaboration-time math helpers
package generic_func_pack;

  function automatic int log2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/avst_pkt_gen_if.sv
// rtl/avst_pkt_gen_if.sv - Avalon-ST style stream interface (avalon_st_if)
interface avalon_st_if #(
  parameter int DATA_WIDTH = 32
);
  import generic_func_pack::*;

  localparam int BYTES   = DATA_WIDTH / 8;
  localparam int EMPTY_W = (BYTES > 1) ? log2(BYTES) : 1;

  logic [DATA_WIDTH-1:0] data;
  logic [EMPTY_W-1:0]    empty;
  logic                  sop;
  logic                  eop;
  logic                  vld;
  logic                  rdy;

  modport master (output data, empty, sop, eop, vld, input rdy);
  modport slave  (input data, empty, sop, eop, vld, output rdy);

endinterface

// File: rtl/avst_beat_fmt.sv
// rtl/avst_beat_fmt.sv - combinational beat builder: byte k of packet p is (p+k) mod 256, byte 0 in MSBs
module avst_beat_fmt
  import avst_pkt_gen_pkg::*;
#(
  parameter int BYTES   = 4,
  parameter int EMPTY_W = 2
) (
  input  logic                 vld_i,
  input  logic [CNT_W-1:0]     pkt_idx_i,
  input  logic [LEN_W-1:0]     byte_off_i,
  input  logic [LEN_W-1:0]     rem_len_i,
  output logic [8*BYTES-1:0]   data_o,
  output logic [EMPTY_W-1:0]   empty_o
);

  always_comb begin
    data_o  = '0;
    empty_o = '0;
    if (vld_i) begin
      for (int i = 0; i < BYTES; i++) begin
        if (LEN_W'(i) < rem_len_i) begin
          data_o[8*(BYTES-1-i) +: 8] = 8'(pkt_idx_i + byte_off_i + LEN_W'(i));
        end
      end
      if (rem_len_i < LEN_W'(BYTES)) begin
        empty_o = EMPTY_W'(LEN_W'(BYTES) - rem_len_i);
      end
    end
  end

endmodule

// File: rtl/avst_pkt_gen.sv
// rtl/avst_pkt_gen.sv - burst packet generator on avalon_st_if; AVST_PKT_GEN_STATS_EN adds beat/stall counters
module avst_pkt_gen
  import avst_pkt_gen_pkg::*;
#(
  parameter int MAX_PKT_BYTES = 2048
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [LEN_W-1:0]   pkt_len_i,
  input  logic [CNT_W-1:0]   num_pkts_i,
  input  logic [GAP_W-1:0]   gap_cycles_i,
  avalon_st_if.master        tx,
  output logic               busy_o,
  output logic               done_o,
  output logic [CNT_W-1:0]   pkt_cnt_o
`ifdef AVST_PKT_GEN_STATS_EN
  ,
  output logic [STAT_W-1:0]  beat_cnt_o,
  output logic [STAT_W-1:0]  stall_cnt_o
`endif
);

  localparam int DW      = $bits(tx.data);
  localparam int BYTES   = DW / 8;
  localparam int EMPTY_W = $bits(tx.empty);

  if ((DW % 8) != 0) begin : g_dw_check
    $error("avst_pkt_gen: tx data width %0d is not a multiple of 8", DW);
  end

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d, off_q, off_d;
  logic [CNT_W-1:0]   num_q, num_d, idx_q, idx_d, pkt_cnt_q, pkt_cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d, gap_cnt_q, gap_cnt_d;
  logic               done_q, done_d;

  logic               vld, xfer, last_beat, accept;
  logic [LEN_W-1:0]   rem_len, req_len;

  assign vld       = (state_q == SEND);
  assign rem_len   = len_q - off_q;
  assign last_beat = (rem_len <= LEN_W'(BYTES));
  assign xfer      = vld && tx.rdy;
  assign accept    = (state_q == IDLE) && start_i;
  assign req_len   = (pkt_len_i > LEN_W'(MAX_PKT_BYTES)) ? LEN_W'(MAX_PKT_BYTES) : pkt_len_i;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    off_d     = off_q;
    num_d     = num_q;
    idx_d     = idx_q;
    pkt_cnt_d = pkt_cnt_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          len_d     = req_len;
          num_d     = num_pkts_i;
          gap_d     = gap_cycles_i;
          idx_d     = '0;
          off_d     = '0;
          pkt_cnt_d = '0;
          // An empty burst completes immediately without entering SEND.
          if ((req_len == '0) || (num_pkts_i == '0)) done_d = 1'b1;
          else state_d = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          if (last_beat) begin
            pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
            idx_d     = idx_q + CNT_W'(1);
            off_d     = '0;
            if (idx_q == num_q - CNT_W'(1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else if (gap_q != '0) begin
              state_d   = GAP;
              gap_cnt_d = gap_q;
            end
          end else begin
            off_d = off_q + LEN_W'(BYTES);
          end
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q - GAP_W'(1);
        if (gap_cnt_q == GAP_W'(1)) state_d = SEND;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      len_q     <= '0;
      off_q     <= '0;
      num_q     <= '0;
      idx_q     <= '0;
      pkt_cnt_q <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      off_q     <= off_d;
      num_q     <= num_d;
      idx_q     <= idx_d;
      pkt_cnt_q <= pkt_cnt_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      done_q    <= done_d;
    end
  end

  avst_beat_fmt #(
    .BYTES   (BYTES),
    .EMPTY_W (EMPTY_W)
  ) u_fmt (
    .vld_i      (vld),
    .pkt_idx_i  (idx_q),
    .byte_off_i (off_q),
    .rem_len_i  (rem_len),
    .data_o     (tx.data),
    .empty_o    (tx.empty)
  );

  // Outputs derive only from registers, so they hold while rdy is low.
  assign tx.vld    = vld;
  assign tx.sop    = vld && (off_q == '0);
  assign tx.eop    = vld && last_beat;
  assign busy_o    = (state_q != IDLE);
  assign done_o    = done_q;
  assign pkt_cnt_o = pkt_cnt_q;

`ifdef AVST_PKT_GEN_STATS_EN
  logic [STAT_W-1:0] beat_cnt_q, beat_cnt_d, stall_cnt_q, stall_cnt_d;

  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (accept) begin
      beat_cnt_d  = '0;
      stall_cnt_d = '0;
    end else begin
      if (xfer && (beat_cnt_q != '1)) beat_cnt_d = beat_cnt_q + STAT_W'(1);
      if (vld && !tx.rdy && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign beat_cnt_o  = beat_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_avst_pkt_gen.sv
// tb/tb_avst_pkt_gen.sv - self-checking bench for avst_pkt_gen at 32-bit data width
module tb_avst_pkt_gen;
  import avst_pkt_gen_pkg::*;

  typedef struct packed {
    logic        vld;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
    logic [31:0] data;
  } beat_t;

  typedef struct {
    int len;
    int num;
    int gap;
    int pct;
    int exp_beats;
    int exp_pkts;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] pkt_len = '0;
  logic [15:0] num_pkts = '0;
  logic [7:0]  gap_cycles = '0;
  logic        busy, done;
  logic [15:0] pkt_cnt;
`ifdef AVST_PKT_GEN_STATS_EN
  logic [31:0] beat_cnt, stall_cnt;
`endif

  avalon_st_if #(.DATA_WIDTH(32)) tx ();

  avst_pkt_gen dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .pkt_len_i    (pkt_len),
    .num_pkts_i   (num_pkts),
    .gap_cycles_i (gap_cycles),
    .tx           (tx),
    .busy_o       (busy),
    .done_o       (done),
    .pkt_cnt_o    (pkt_cnt)
`ifdef AVST_PKT_GEN_STATS_EN
    ,
    .beat_cnt_o   (beat_cnt),
    .stall_cnt_o  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  beat_t got_q[$];
  vec_t  vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic beat_t sample();
    beat_t b;
    b = {tx.vld, tx.sop, tx.eop, tx.empty, tx.data};
    return b;
  endfunction

  function automatic beat_t mk(input logic s, input logic e, input logic [1:0] emp, input logic [31:0] d);
    beat_t b;
    b = {1'b1, s, e, emp, d};
    return b;
  endfunction

  // Reference: enumerate the packet bytes and chop them into 4-byte beats.
  task automatic build_model(input int len, input int num);
    int l;
    beat_t b;
    l = (len > 2048) ? 2048 : len;
    exp_q.delete();
    for (int p = 0; p < num; p++) begin
      for (int k = 0; k < l; k += 4) begin
        b       = '0;
        b.vld   = 1'b1;
        b.sop   = (k == 0);
        b.eop   = (k + 4 >= l);
        b.empty = (l - k >= 4) ? 2'd0 : 2'(4 - (l - k));
        for (int j = 0; j < 4; j++) begin
          if (k + j < l) b.data[31-8*j -: 8] = 8'((p + k + j) % 256);
        end
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic run_burst(input int len, input int num, input int gap, input int pct,
                           input string tag, output int nbeats);
    beat_t cur, prev;
    bit    prev_stall, gap_open, finished, active;
    int    idle_run;
    nbeats = 0; prev = '0; prev_stall = 0; gap_open = 0; finished = 0; idle_run = 0;
    active = (len != 0) && (num != 0);
    build_model(len, num);
    got_q.delete();
    @(negedge clk);
    start = 1'b1; pkt_len = 16'(len); num_pkts = 16'(num); gap_cycles = 8'(gap); tx.rdy = 1'b0;
    @(negedge clk);
    start = 1'b0; pkt_len = 16'($urandom); num_pkts = 16'($urandom); gap_cycles = 8'($urandom);
    check({tag, " busy after start"}, busy, active);
    check({tag, " vld/sop at N+1"}, {tx.vld, tx.sop}, active ? 2'b11 : 2'b00);
    if (!active) begin
      check({tag, " done at N+1"}, done, 1);
      return;
    end
    for (int cyc = 0; cyc < 5000 && !finished; cyc++) begin
      cur = sample();
      if (prev_stall) check({tag, " hold while stalled"}, cur, prev);
      if (cur.vld) begin
        if (gap_open) check({tag, " gap length"}, idle_run, gap);
        gap_open = 0;
      end else begin
        idle_run++;
      end
      tx.rdy = ($urandom_range(99) < pct);
      if (cur.vld && tx.rdy) begin
        nbeats++;
        got_q.push_back(cur);
        if (exp_q.size() == 0) check({tag, " unexpected beat"}, cur, 0);
        else check({tag, " beat"}, cur, exp_q.pop_front());
        if (cur.eop) begin
          if (exp_q.size() == 0) finished = 1;
          else begin gap_open = 1; idle_run = 0; end
        end
      end
      prev = cur;
      prev_stall = cur.vld && !tx.rdy;
      @(negedge clk);
    end
    check({tag, " burst completed"}, finished, 1);
    check({tag, " done/busy/vld after last eop"}, {done, busy, tx.vld}, 3'b100);
    @(negedge clk);
    check({tag, " done single pulse"}, done, 0);
  endtask

  initial begin
    int nb, n, len, num;
    tx.rdy = 1'b0;

    repeat (3) @(negedge clk);
    check("reset vld/sop/eop/busy/done", {tx.vld, tx.sop, tx.eop, busy, done}, 0);
    check("reset data/empty", {tx.data, tx.empty}, 0);
    check("reset pkt_cnt", pkt_cnt, 0);
    rst = 1'b0;

    run_burst(10, 1, 0, 100, "len10", nb);
    check("len10 beats", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("len10 beat0", got_q[0], mk(1, 0, 2'd0, 32'h00010203));
      check("len10 beat1", got_q[1], mk(0, 0, 2'd0, 32'h04050607));
      check("len10 beat2", got_q[2], mk(0, 1, 2'd2, 32'h08090000));
    end
    check("len10 pkt_cnt", pkt_cnt, 1);

    run_burst(4, 3, 2, 100, "len4x3", nb);
    check("len4x3 beats", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("len4x3 beat0", got_q[0], mk(1, 1, 2'd0, 32'h00010203));
      check("len4x3 beat1", got_q[1], mk(1, 1, 2'd0, 32'h01020304));
      check("len4x3 beat2", got_q[2], mk(1, 1, 2'd0, 32'h02030405));
    end
    check("len4x3 pkt_cnt", pkt_cnt, 3);

    vecs[0] = '{9, 2, 0, 50, 6, 2};
    vecs[1] = '{1, 3, 0, 100, 3, 3};
    vecs[2] = '{5, 2, 1, 70, 4, 2};
    vecs[3] = '{0, 5, 0, 100, 0, 0};
    vecs[4] = '{8, 0, 3, 100, 0, 0};
    vecs[5] = '{3000, 1, 0, 100, 512, 1};
    vecs[6] = '{7, 4, 3, 60, 8, 4};
    vecs[7] = '{16, 2, 0, 40, 8, 2};
    for (int i = 0; i < 8; i++) begin
      run_burst(vecs[i].len, vecs[i].num, vecs[i].gap, vecs[i].pct, $sformatf("vec%0d", i), nb);
      check($sformatf("vec%0d beat count", i), nb, vecs[i].exp_beats);
      check($sformatf("vec%0d pkt_cnt", i), pkt_cnt, vecs[i].exp_pkts);
    end

    for (int i = 0; i < 6; i++) begin
      len = $urandom_range(40, 1);
      num = $urandom_range(4, 1);
      run_burst(len, num, $urandom_range(3, 0), $urandom_range(100, 30), $sformatf("rnd%0d", i), nb);
      check($sformatf("rnd%0d pkt_cnt", i), pkt_cnt, num);
    end

    // start while busy must be ignored
    @(negedge clk);
    start = 1'b1; pkt_len = 16'd8; num_pkts = 16'd1; gap_cycles = 8'd0; tx.rdy = 1'b0;
    @(negedge clk);
    pkt_len = 16'd4; num_pkts = 16'd3;
    check("ignore busy", busy, 1);
    @(negedge clk);
    start = 1'b0; tx.rdy = 1'b1;
    check("ignore first beat", sample(), mk(1, 0, 2'd0, 32'h00010203));
    n = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (tx.vld && tx.rdy) n++;
      @(negedge clk);
    end
    check("ignore beats", n, 2);
    check("ignore done", done, 1);
    check("ignore pkt_cnt", pkt_cnt, 1);
    @(negedge clk);
    check("ignore stays idle", {busy, tx.vld}, 0);

    // reset while the second beat of a 3-beat packet is presented
    start = 1'b1; pkt_len = 16'd12; num_pkts = 16'd1; tx.rdy = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("midrst second beat", {tx.vld, tx.sop, tx.eop}, 3'b100);
    rst = 1'b1;
    @(negedge clk);
    check("midrst vld/eop/busy/done", {tx.vld, tx.eop, busy, done}, 0);
    check("midrst data/empty", {tx.data, tx.empty}, 0);
    check("midrst pkt_cnt", pkt_cnt, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst stays idle", {tx.vld, busy}, 0);

`ifdef AVST_PKT_GEN_STATS_EN
    start = 1'b1; pkt_len = 16'd16; num_pkts = 16'd2; gap_cycles = 8'd0; tx.rdy = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    tx.rdy = 1'b1;
    for (int c = 0; c < 40 && !done; c++) @(negedge clk);
    check("stats done", done, 1);
    check("stats stall_cnt", stall_cnt, 10);
    check("stats beat_cnt", beat_cnt, 8);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/avst_pkt_gen.md
AVST_PKT_GEN -- requirements
Module: avst_pkt_gen

Interface
REQ-001 Parameter MAX_PKT_BYTES, default 2048: maximum packet length in bytes; larger requests clamp to this value.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to begin a burst; sampled only when busy=0.
REQ-005 pkt_len  input  16  bytes per packet; sampled on accepted start.
REQ-006 num_pkts  input  16  packets per burst; sampled on accepted start.
REQ-007 gap_cycles  input  8  idle cycles between packets; sampled on accepted start.
REQ-008 tx  avalon_st_if  --  generator side: block drives data, empty, sop, eop and vld; samples rdy.
REQ-009 busy  output  1  burst in progress.
REQ-010 done  output  1  one-cycle pulse when a burst completes.
REQ-011 pkt_cnt  output  16  packets fully transferred in the current or last burst.

Function
REQ-012 BYTES = tx.DATA_WIDTH/8; tx.DATA_WIDTH SHALL be a multiple of 8, checked by an elaboration-time $error.
REQ-013 A beat SHALL transfer only on a cycle with tx.vld=1 and tx.rdy=1.
REQ-014 While tx.vld=1 and tx.rdy=0, data, empty, sop, eop and vld SHALL hold stable.
REQ-015 FSM states: IDLE, SEND, GAP.
- IDLE->SEND on start=1 with pkt_len!=0 and num_pkts!=0.
- SEND->GAP on eop transfer when more packets remain and gap_cycles!=0.
- SEND->SEND on eop transfer when more packets remain and gap_cycles=0 (back-to-back).
- SEND->IDLE on the last eop transfer.
- GAP->SEND after exactly gap_cycles cycles with vld=0.
REQ-016 start sampled at cycle N SHALL give tx.vld=1 with sop=1 at cycle N+1.
REQ-017 start with pkt_len=0 or num_pkts=0 SHALL give no beats, done=1 at N+1, and pkt_cnt=0.
REQ-018 start while busy=1 SHALL be ignored.
REQ-019 Payload: byte k of packet p SHALL equal (p + k) mod 256, with p counted from 0 within the burst.
REQ-020 Byte 0 of each beat SHALL be in tx.data MSBs.
REQ-021 Beats per packet SHALL be ceil(len/BYTES); sop on the first beat, eop on the last, both on a single-beat packet.
REQ-022 tx.empty SHALL equal the unused bytes in the eop beat, SHALL be 0 on all other beats, and unused bytes SHALL be driven 0.
REQ-023 pkt_cnt SHALL clear on an accepted start and increment on each eop transfer; 16-bit wrap is unreachable because it is bounded by num_pkts.
REQ-024 busy=1 from the cycle after an accepted start until the cycle done pulses; done and busy=0 SHALL occur in the cycle after the last eop transfer.

Reset
REQ-025 On rst=1 at a clock edge: state=IDLE; tx.vld, sop, eop, busy and done = 0; tx.data and tx.empty = 0; pkt_cnt = 0.
REQ-026 Reset mid-packet SHALL drop tx.vld the next cycle without emitting eop; the partial packet is abandoned.

Configuration
REQ-027 Macro AVST_PKT_GEN_STATS_EN defined: add outputs beat_cnt[31:0] (beat transfers) and stall_cnt[31:0] (cycles with vld=1 and rdy=0).
- Both SHALL be 32-bit, saturating, cleared on rst and on accepted start.
REQ-028 Macro undefined: beat_cnt and stall_cnt ports and logic SHALL be absent; all other behaviour identical.

Structure
REQ-029 Package avst_pkt_gen_pkg SHALL hold the FSM state enum typedef and the length/count width constants; generic_func_pack helpers SHALL be reused for log2 and pow2 checks.
REQ-030 Sub-module avst_beat_fmt SHALL build data and empty from the packet index, byte offset and remaining length; it is combinational, while the counters and FSM stay in avst_pkt_gen.

Verification (DATA_WIDTH=32)
REQ-031 pkt_len=10, num_pkts=1, gap=0, rdy=1 -> beats 0x00010203 (sop), 0x04050607, 0x08090000 (eop, empty=2); done 1 cycle after the eop beat; pkt_cnt=1.
REQ-032 pkt_len=4, num_pkts=3, gap=2 -> three single beats with sop=eop=1, data 0x00010203, 0x01020304, 0x02030405; exactly 2 vld=0 cycles between them.
REQ-033 pkt_len=9, num_pkts=2, rdy pseudo-random 50% -> outputs stable while stalled; 6 beats total; byte sequence matches REQ-019.
REQ-034 rst asserted on the second beat of a 3-beat packet -> vld=0 next cycle, no eop, busy=0, pkt_cnt=0.
REQ-035 start with pkt_len=0 -> no vld, done at N+1; with STATS_EN: 10 forced stall cycles during a burst -> stall_cnt=10, beat_cnt equal to the transferred beats.
